// File: rtl/tmds_channel_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_channel_encoder_if
//  Description : Symbol-request and encoded-character bundle for one TMDS
//                channel encoder. The master drives symbol requests; the
//                slave (the encoder) returns the 10-bit character.
//  Revision    : 1.0  initial release
// ============================================================================
interface tmds_channel_encoder_if;
    logic       pix_en;
    logic [1:0] mode;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [9:0] tmds_out;
    logic       tmds_valid;

    modport master (
        output pix_en,
        output mode,
        output ctrl,
        output data,
        input  tmds_out,
        input  tmds_valid
    );

    modport slave (
        input  pix_en,
        input  mode,
        input  ctrl,
        input  data,
        output tmds_out,
        output tmds_valid
    );
endinterface
`default_nettype wire

// File: rtl/tmds_channel_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_channel_encoder
//  Description : Two-stage pipelined TMDS 8b/10b encoder for one HDMI/DVI
//                channel. Stage 1 captures the request and forms the
//                transition-minimised word q_m; stage 2 selects the control,
//                guard or DC-balanced video character and tracks disparity.
//  Revision    : 1.0  initial release
// ============================================================================
module tmds_channel_encoder #(
    parameter int CHANNEL = 0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    tmds_channel_encoder_if.slave  bus
);

    localparam logic [1:0] C_MODE_GUARD = 2'b01;
    localparam logic [1:0] C_MODE_VIDEO = 2'b10;

    localparam logic [9:0] C_CTRL_00    = 10'h354;
    localparam logic [9:0] C_CTRL_01    = 10'h0AB;
    localparam logic [9:0] C_CTRL_10    = 10'h154;
    localparam logic [9:0] C_CTRL_11    = 10'h2AB;
    localparam logic [9:0] C_GUARD_TOK  = (CHANNEL == 1) ? 10'h133 : 10'h2CC;

    // Stage-1 registers
    logic [1:0] mode_q, mode_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic [8:0] qm_q,   qm_d;

    // Stage-2 registers
    logic [9:0] tmds_q, tmds_d;
    logic       valid_q, valid_d;
    logic [4:0] cnt_q,  cnt_d;      // two's-complement running disparity

    // Stage-1 combinational helpers
    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] qm_word;

    // Stage-2 combinational helpers
    logic [3:0] n1;
    logic [4:0] diff;               // n1 - n0 of q_m[7:0], two's complement
    logic       cnt_pos;
    logic       cnt_neg;

    // Transition-minimising front end: choose XOR/XNOR chain from the ones count
    always_comb begin
        n1d = '0;
        for (int i = 0; i < 8; i++) begin
            n1d = n1d + {3'b000, bus.data[i]};
        end
        use_xnor   = (n1d > 4'd4) || ((n1d == 4'd4) && !bus.data[0]);
        qm_word    = '0;
        qm_word[0] = bus.data[0];
        for (int i = 1; i < 8; i++) begin
            qm_word[i] = use_xnor ? ~(qm_word[i-1] ^ bus.data[i])
                                  :  (qm_word[i-1] ^ bus.data[i]);
        end
        qm_word[8] = ~use_xnor;
    end

    // Stage-1 next state: capture the request on each strobe, otherwise hold
    always_comb begin
        mode_d = mode_q;
        ctrl_d = ctrl_q;
        qm_d   = qm_q;
        if (bus.pix_en) begin
            mode_d = bus.mode;
            ctrl_d = bus.ctrl;
            qm_d   = qm_word;
        end
    end

    // Balance of the stored q_m byte; diff wraps correctly on 5 bits even for n1=8
    always_comb begin
        n1 = '0;
        for (int i = 0; i < 8; i++) begin
            n1 = n1 + {3'b000, qm_q[i]};
        end
        diff    = {n1, 1'b0} - 5'd8;
        cnt_neg = cnt_q[4];
        cnt_pos = !cnt_q[4] && (cnt_q != 5'd0);
    end

    // Stage-2 next state: character selection and disparity update
    always_comb begin
        tmds_d  = tmds_q;
        cnt_d   = cnt_q;
        valid_d = bus.pix_en;
        if (bus.pix_en) begin
            if (mode_q == C_MODE_VIDEO) begin
                if ((cnt_q == 5'd0) || (n1 == 4'd4)) begin
                    tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                    cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
                end else if ((cnt_pos && (n1 > 4'd4)) || (cnt_neg && (n1 < 4'd4))) begin
                    tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                    cnt_d  = cnt_q + {3'b000, qm_q[8], 1'b0} - diff;
                end else begin
                    tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
                    cnt_d  = cnt_q + diff - {3'b000, ~qm_q[8], 1'b0};
                end
            end else if (mode_q == C_MODE_GUARD) begin
                tmds_d = C_GUARD_TOK;
                cnt_d  = 5'd0;
            end else begin
                // Reserved mode 11 falls through to control
                case (ctrl_q)
                    2'b00:   tmds_d = C_CTRL_00;
                    2'b01:   tmds_d = C_CTRL_01;
                    2'b10:   tmds_d = C_CTRL_10;
                    default: tmds_d = C_CTRL_11;
                endcase
                cnt_d = 5'd0;
            end
        end
    end

    // Pipeline registers; reset wins over the strobe and flushes both stages
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= 2'b00;
            ctrl_q  <= 2'b00;
            qm_q    <= '0;
            tmds_q  <= C_CTRL_00;
            valid_q <= 1'b0;
            cnt_q   <= 5'd0;
        end else begin
            mode_q  <= mode_d;
            ctrl_q  <= ctrl_d;
            qm_q    <= qm_d;
            tmds_q  <= tmds_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.tmds_out   = tmds_q;
    assign bus.tmds_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_tmds_channel_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tmds_channel_encoder
//  Description : Scoreboard bench for tmds_channel_encoder. Channel 0 and
//                channel 1 instances see identical requests; expected
//                characters are queued per instance as requests are driven
//                and consumed whenever the instance reports a new character.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tmds_channel_encoder;

    logic clk;
    logic rst;

    tmds_channel_encoder_if bif0 ();
    tmds_channel_encoder_if bif1 ();

    tmds_channel_encoder #(.CHANNEL(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bif0.slave));
    tmds_channel_encoder #(.CHANNEL(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bif1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];
    int         cnt0;
    int         cnt1;
    logic [9:0] last0;
    logic [9:0] last1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoder, written straight from the character tables and balance rules
    task automatic model_enc(input int chan, input logic [1:0] m, input logic [1:0] c,
                             input logic [7:0] d, inout int cnt, output logic [9:0] tok);
        int         ones;
        int         k1;
        int         k0;
        logic       xn;
        logic [8:0] qm;
        if (m == 2'b10) begin
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(d[i]);
            xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
            qm = '0;
            qm[0] = d[0];
            for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
            qm[8] = ~xn;
            k1 = 0;
            for (int i = 0; i < 8; i++) k1 += int'(qm[i]);
            k0 = 8 - k1;
            if (cnt == 0 || k1 == k0) begin
                tok = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                cnt = cnt + (qm[8] ? (k1 - k0) : (k0 - k1));
            end else if ((cnt > 0 && k1 > k0) || (cnt < 0 && k0 > k1)) begin
                tok = {1'b1, qm[8], ~qm[7:0]};
                cnt = cnt + (qm[8] ? 2 : 0) + (k0 - k1);
            end else begin
                tok = {1'b0, qm[8], qm[7:0]};
                cnt = cnt + (k1 - k0) - (qm[8] ? 0 : 2);
            end
        end else if (m == 2'b01) begin
            tok = (chan == 1) ? 10'h133 : 10'h2CC;
            cnt = 0;
        end else begin
            case (c)
                2'b00:   tok = 10'h354;
                2'b01:   tok = 10'h0AB;
                2'b10:   tok = 10'h154;
                default: tok = 10'h2AB;
            endcase
            cnt = 0;
        end
    endtask

    // After reset, stage 1 holds a control-00 request that emerges on the first strobe
    task automatic sb_init();
        exp_q0.delete();
        exp_q1.delete();
        exp_q0.push_back(10'h354);
        exp_q1.push_back(10'h354);
        cnt0 = 0;
        cnt1 = 0;
    endtask

    task automatic strobe(input logic [1:0] m, input logic [1:0] c, input logic [7:0] d);
        logic [9:0] t0;
        logic [9:0] t1;
        @(negedge clk);
        bif0.pix_en = 1'b1; bif0.mode = m; bif0.ctrl = c; bif0.data = d;
        bif1.pix_en = 1'b1; bif1.mode = m; bif1.ctrl = c; bif1.data = d;
        model_enc(0, m, c, d, cnt0, t0);
        model_enc(1, m, c, d, cnt1, t1);
        exp_q0.push_back(t0);
        exp_q1.push_back(t1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bif0.pix_en = 1'b0;
            bif1.pix_en = 1'b0;
        end
    endtask

    task automatic pulse_reset(input int cycles, input string tag);
        @(negedge clk);
        rst = 1'b1;
        bif0.pix_en = 1'b0;
        bif1.pix_en = 1'b0;
        repeat (cycles - 1) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_init();
        check_eq({tag, "_out0"},   32'(bif0.tmds_out),   32'h354);
        check_eq({tag, "_out1"},   32'(bif1.tmds_out),   32'h354);
        check_eq({tag, "_valid0"}, 32'(bif0.tmds_valid), 32'h0);
        check_eq({tag, "_valid1"}, 32'(bif1.tmds_valid), 32'h0);
    endtask

    // Scoreboard consumer: every new character must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && bif0.tmds_valid) begin
            if (exp_q0.size() == 0) begin
                check_eq("ch0_underflow", 32'(bif0.tmds_out), 32'hFFFF_FFFF);
            end else begin
                last0 = exp_q0.pop_front();
                check_eq("ch0_out", 32'(bif0.tmds_out), 32'(last0));
            end
        end
        if (!rst && bif1.tmds_valid) begin
            if (exp_q1.size() == 0) begin
                check_eq("ch1_underflow", 32'(bif1.tmds_out), 32'hFFFF_FFFF);
            end else begin
                last1 = exp_q1.pop_front();
                check_eq("ch1_out", 32'(bif1.tmds_out), 32'(last1));
            end
        end
    end

    initial begin
        rst = 1'b1;
        bif0.pix_en = 1'b0; bif0.mode = 2'b00; bif0.ctrl = 2'b00; bif0.data = 8'h00;
        bif1.pix_en = 1'b0; bif1.mode = 2'b00; bif1.ctrl = 2'b00; bif1.data = 8'h00;
        last0 = 10'h354;
        last1 = 10'h354;
        sb_init();

        // Power-on reset held for two cycles
        pulse_reset(2, "reset");

        // Control idle, then every control token, then reserved mode
        repeat (3) strobe(2'b00, 2'b00, 8'h00);
        for (int i = 0; i < 4; i++) strobe(2'b00, 2'(i), 8'h00);
        strobe(2'b11, 2'b10, 8'h00);

        // Guard band followed by video 0x00 restarting from zero disparity
        strobe(2'b01, 2'b00, 8'h00);
        strobe(2'b10, 2'b00, 8'h00);

        // Disparity walk with ten zero pixels
        strobe(2'b00, 2'b00, 8'h00);
        for (int i = 0; i < 10; i++) strobe(2'b10, 2'b00, 8'h00);

        // XNOR path from a fresh disparity
        strobe(2'b00, 2'b00, 8'h00);
        strobe(2'b10, 2'b00, 8'hFF);
        strobe(2'b00, 2'b01, 8'h00);

        // Output holds with the strobe low
        idle(1);
        idle(3);
        check_eq("hold_out0",   32'(bif0.tmds_out),   32'(last0));
        check_eq("hold_out1",   32'(bif1.tmds_out),   32'(last1));
        check_eq("hold_valid0", 32'(bif0.tmds_valid), 32'h0);

        // Reset in the middle of a video run with nonzero disparity
        strobe(2'b00, 2'b00, 8'h00);
        repeat (3) strobe(2'b10, 2'b00, 8'h00);
        pulse_reset(1, "midrst");
        strobe(2'b10, 2'b00, 8'h00);
        strobe(2'b00, 2'b00, 8'h00);
        strobe(2'b00, 2'b00, 8'h00);

        // Mixed traffic with strobe gaps
        for (int i = 0; i < 60; i++) begin
            logic [1:0] rm;
            rm = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom_range(0, 3));
            strobe(rm, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        // Flush: one more strobe pushes the last request through
        strobe(2'b00, 2'b00, 8'h00);
        idle(3);
        check_eq("drain_q0", 32'(exp_q0.size()), 32'd1);
        check_eq("drain_q1", 32'(exp_q1.size()), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
